muldiv_sequencer: RTL and testbench
===================================

// Module: muldiv_sequencer
// PURPOSE
//  Iterative multiply/divide sequencer for the pipelined MIPS core, sitting beside the EX-stage ALU.
//  Accepts MULTU/DIVU (MULT/DIV optional) from EX, runs a 1-bit/cycle shift-add or restoring-divide
//  datapath, and commits the result to HI/LO. Stalls the pipeline when a new mul/div or an mfhi/mflo
//  arrives while an operation is still in flight.
// PARAMETERS
//  WIDTH   32  operand width; HI and LO are each WIDTH bits
//  CNT_W   6   iteration counter width; must satisfy 2**CNT_W > WIDTH
// PORTS
//  clk      in   1      clock, rising edge
//  rst      in   1      asynchronous reset, active-high
//  start    in   1      EX holds a mul/div; valid for one accepted cycle
//  op       in   2      00 MULTU, 01 DIVU, 10 MULT, 11 DIV
//  opnd_a   in   WIDTH  rs value (multiplicand / dividend)
//  opnd_b   in   WIDTH  rt value (multiplier / divisor)
//  rd_req   in   1      ID/EX holds mfhi or mflo
//  busy     out  1      state != IDLE
//  done     out  1      one-cycle pulse: HI/LO updated this edge
//  stall    out  1      freeze PC, IF/ID and ID/EX
//  hi_out   out  WIDTH  HI register
//  lo_out   out  WIDTH  LO register
// BEHAVIOUR
//  - Reset (async, rst=1): state=IDLE, cnt=0, hi_out=0, lo_out=0, busy=0, done=0; all working regs cleared.
//    Reset mid-operation discards that operation. HI/LO are not updated.
//  - FSM: IDLE -> BUSY on start; BUSY -> DONE when cnt==WIDTH-1; DONE -> IDLE unconditionally.
//  - Accept: start is accepted only in IDLE. Operands and op are latched that edge and cnt is cleared.
//  - BUSY, multiply: if acc_lo[0], then {carry,acc_hi} = acc_hi + mcand.
//    Then {acc_hi,acc_lo} is shifted right 1 with carry in.
//  - BUSY, divide: shift {rem,quo} left 1.
//    If rem >= divisor, subtract the divisor and set quo[0]=1.
//    Arithmetic uses WIDTH+1 bits.
//  - DONE: HI <= acc_hi or remainder; LO <= acc_lo or quotient; done=1 this cycle only.
//    Latency is start edge -> done = WIDTH+1 cycles (33 at default), and HI/LO are visible next cycle.
//  - Divide by zero: runs the full latency with no early exit. Result is HI=dividend, LO={WIDTH{1'b1}}.
//  - stall = (state!=IDLE) & (start | rd_req). It is combinational and releases in the cycle after DONE.
//  - start while BUSY/DONE: not accepted and stall=1, so EX re-presents it. There is no queueing.
//  - start and rd_req together in IDLE: the start is accepted and stall=0.
//    The older instruction owns HI/LO, so the read sees the pre-op value.
//  - hi_out/lo_out change only on the DONE edge or on reset.
// CONFIGURATION
//  MULDIV_SIGNED_EN defined:
//   - op[1]=1 selects a signed op. Operands are converted to magnitude on accept, and the result
//     sign is fixed on the DONE edge (no extra cycle).
//   - Signed multiply: negate the full 2*WIDTH product if a[MSB]^b[MSB].
//   - Signed divide: negate the quotient if a^b signs differ; the remainder takes the dividend's sign.
//   - Divide by zero still yields HI=dividend, LO=all-ones.
//  MULDIV_SIGNED_EN undefined: op[1] is ignored; MULT/DIV execute as MULTU/DIVU. No sign logic is built.
// TESTING
//  1. rst pulse mid-BUSY -> busy/done=0 immediately; HI/LO=0; a new start accepted next edge.
//  2. MULTU 0xFFFFFFFF*0xFFFFFFFF -> done at edge 33; HI=0xFFFFFFFE, LO=0x00000001.
//  3. DIVU 100/7 -> HI=2, LO=14; DIVU 5/0 -> HI=5, LO=0xFFFFFFFF after full latency.
//  4. rd_req held from cycle 2 of BUSY -> stall=1 through DONE, 0 next cycle; the read returns the new HI.
//  5. Back-to-back start: second start held during BUSY -> stall=1; accepted the cycle after DONE; both results correct.
//  6. [MULDIV_SIGNED_EN] MULT -3*5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1; DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
//     Without the macro the same MULT gives the unsigned product.

Source files
------------

// File: rtl/muldiv_sequencer_if.sv
// EX-stage <-> multiply/divide sequencer port bundle.
// Handshake: EX raises start with op/opnd_a/opnd_b and holds them until a rising edge
// sees start=1 while busy=0; that edge takes the request. While busy=1, start is not taken
// and stall=1 tells EX to keep presenting it. done pulses for one cycle before HI/LO change.
interface muldiv_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] opnd_a;
  logic [WIDTH-1:0] opnd_b;
  logic             rd_req;
  logic             busy;
  logic             done;
  logic             stall;
  logic [WIDTH-1:0] hi_out;
  logic [WIDTH-1:0] lo_out;
  logic [1:0]       fsm_state;

  modport master (
    output start, op, opnd_a, opnd_b, rd_req,
    input  busy, done, stall, hi_out, lo_out, fsm_state
  );

  modport slave (
    input  start, op, opnd_a, opnd_b, rd_req,
    output busy, done, stall, hi_out, lo_out, fsm_state
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative 1-bit/cycle multiply (shift-add) / divide (restoring) unit committing to HI/LO.
// Optional signed MULT/DIV support is built when MULDIV_SIGNED_EN is defined.
module muldiv_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  muldiv_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             last;

  // operand holds the multiplicand or the divisor; acc_lo holds multiplier or dividend/quotient
  logic [WIDTH-1:0] operand;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic             is_div;
  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] lo_r;

  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] div_rem;
  logic [WIDTH-1:0] res_hi;
  logic [WIDTH-1:0] res_lo;

`ifdef MULDIV_SIGNED_EN
  logic             neg_res;
  logic             neg_rem;
  logic             div_zero;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_neg;
`else
  logic             unused_sign_sel;
  assign unused_sign_sel = bus.op[1];
`endif

  assign accept = (state == IDLE) && bus.start;
  assign last   = (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = BUSY;
      BUSY:    if (last)      state_nxt = DONE;
      DONE:                   state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_comb begin
`ifdef MULDIV_SIGNED_EN
    a_in = (bus.op[1] && bus.opnd_a[WIDTH-1]) ? -bus.opnd_a : bus.opnd_a;
    b_in = (bus.op[1] && bus.opnd_b[WIDTH-1]) ? -bus.opnd_b : bus.opnd_b;
`else
    a_in = bus.opnd_a;
    b_in = bus.opnd_b;
`endif
    mul_sum   = {1'b0, acc_hi} + ({1'b0, operand} & {(WIDTH+1){acc_lo[0]}});
    div_shift = {acc_hi, acc_lo[WIDTH-1]};
    div_diff  = div_shift - {1'b0, operand};
    div_ge    = (div_shift >= {1'b0, operand});
    div_rem   = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
  end

  // Sign correction happens combinationally so the DONE edge commits the final value
  always_comb begin
    res_hi = acc_hi;
    res_lo = acc_lo;
`ifdef MULDIV_SIGNED_EN
    prod     = {acc_hi, acc_lo};
    prod_neg = -prod;
    if (is_div) begin
      res_hi = neg_rem ? -acc_hi : acc_hi;
      if (div_zero)     res_lo = '1;
      else if (neg_res) res_lo = -acc_lo;
    end else if (neg_res) begin
      res_hi = prod_neg[2*WIDTH-1:WIDTH];
      res_lo = prod_neg[WIDTH-1:0];
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      operand <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      is_div  <= 1'b0;
      hi_r    <= '0;
      lo_r    <= '0;
`ifdef MULDIV_SIGNED_EN
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
`endif
    end else if (accept) begin
      cnt    <= '0;
      is_div <= bus.op[0];
      acc_hi <= '0;
      if (bus.op[0]) begin
        operand <= b_in;
        acc_lo  <= a_in;
      end else begin
        operand <= a_in;
        acc_lo  <= b_in;
      end
`ifdef MULDIV_SIGNED_EN
      neg_res  <= bus.op[1] & (bus.opnd_a[WIDTH-1] ^ bus.opnd_b[WIDTH-1]);
      neg_rem  <= bus.op[1] & bus.opnd_a[WIDTH-1];
      div_zero <= (bus.opnd_b == '0);
`endif
    end else if (state == BUSY) begin
      cnt <= cnt + CNT_W'(1);
      if (is_div) begin
        acc_hi <= div_rem;
        acc_lo <= {acc_lo[WIDTH-2:0], div_ge};
      end else begin
        acc_hi <= mul_sum[WIDTH:1];
        acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
      end
    end else if (state == DONE) begin
      hi_r <= res_hi;
      lo_r <= res_lo;
    end
  end

  assign bus.busy      = (state != IDLE);
  assign bus.done      = (state == DONE);
  assign bus.stall     = (state != IDLE) && (bus.start || bus.rd_req);
  assign bus.hi_out    = hi_r;
  assign bus.lo_out    = lo_r;
  assign bus.fsm_state = state;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: latency, results, stall behaviour and reset.
// Expected values are hand-computed; MULDIV_SIGNED_EN selects the signed expectations.
module tb_muldiv_sequencer;
  localparam int WIDTH = 32;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  logic [2*WIDTH-1:0] exp_q[$];

  muldiv_sequencer_if #(.WIDTH(WIDTH)) bus ();

  muldiv_sequencer #(.WIDTH(WIDTH), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input string tag, output int n);
    n = 0;
    while (!bus.done && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, " latency"}, 64'(n + 1), 64'(WIDTH + 1));
  endtask

  task automatic check_result(input string tag);
    logic [2*WIDTH-1:0] e;
    if (exp_q.size() == 0) begin
      check({tag, " queue empty"}, 64'(0), 64'(1));
    end else begin
      e = exp_q.pop_front();
      check({tag, " hi"}, 64'(bus.hi_out), 64'(e[2*WIDTH-1:WIDTH]));
      check({tag, " lo"}, 64'(bus.lo_out), 64'(e[WIDTH-1:0]));
    end
  endtask

  // driver: present an op from idle, wait for completion, compare after the DONE edge
  task automatic run_op(input string tag, input logic [1:0] op, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] eh, input logic [WIDTH-1:0] el);
    int n;
    exp_q.push_back({eh, el});
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.opnd_a = a; bus.opnd_b = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check({tag, " busy"}, 64'(bus.busy), 64'(1));
    wait_done(tag, n);
    @(posedge clk); #1;
    check({tag, " done pulse"}, 64'(bus.done), 64'(0));
    check_result(tag);
  endtask

  initial begin
    int n;
    int bad;
    checks = 0; failures = 0;
    rst = 1'b1;
    bus.start = 1'b0; bus.op = 2'b00; bus.opnd_a = '0; bus.opnd_b = '0; bus.rd_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", 64'(bus.busy), 64'(0));
    check("reset done", 64'(bus.done), 64'(0));
    check("reset hi", 64'(bus.hi_out), 64'(0));
    check("reset lo", 64'(bus.lo_out), 64'(0));
    check("reset state", 64'(bus.fsm_state), 64'(0));
    @(negedge clk); rst = 1'b0;

    run_op("multu max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("divu 100/7", 2'b01, 32'd100, 32'd7, 32'd2, 32'd14);
    run_op("divu 5/0", 2'b01, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF);

    // rd_req alone in idle must not stall
    @(negedge clk); bus.rd_req = 1'b1; #1;
    check("idle rd stall", 64'(bus.stall), 64'(0));
    bus.rd_req = 1'b0;

    // rd_req raised in the second BUSY cycle
    exp_q.push_back({32'd3, 32'd0});
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b00; bus.opnd_a = 32'h0001_0000; bus.opnd_b = 32'h0003_0000;
    @(posedge clk); #1; bus.start = 1'b0;
    @(posedge clk); #1; bus.rd_req = 1'b1; #1;
    check("rd stall first", 64'(bus.stall), 64'(1));
    n = 0; bad = 0;
    while (!bus.done && n < 200) begin
      @(posedge clk); #1;
      n++;
      if (!bus.stall) bad++;
    end
    check("rd stall held", 64'(bad), 64'(0));
    check("rd done seen", 64'(bus.done), 64'(1));
    check("rd old hi at done", 64'(bus.hi_out), 64'(5));
    @(posedge clk); #1;
    check("rd stall release", 64'(bus.stall), 64'(0));
    check_result("rd read");
    bus.rd_req = 1'b0;

    // start+rd together in idle, then a second start held through the first op
    exp_q.push_back({32'd0, 32'd156});
    exp_q.push_back({32'd10, 32'd30});
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b00; bus.opnd_a = 32'd12; bus.opnd_b = 32'd13; bus.rd_req = 1'b1;
    #1;
    check("start+rd stall", 64'(bus.stall), 64'(0));
    check("start+rd pre-op hi", 64'(bus.hi_out), 64'(3));
    @(posedge clk); #1;
    bus.rd_req = 1'b0; bus.op = 2'b01; bus.opnd_a = 32'd1000; bus.opnd_b = 32'd33; #1;
    check("b2b stall", 64'(bus.stall), 64'(1));
    n = 0; bad = 0;
    while (!bus.done && n < 200) begin
      @(posedge clk); #1;
      n++;
      if (!bus.stall) bad++;
    end
    check("b2b stall held", 64'(bad), 64'(0));
    check("b2b first latency", 64'(n + 1), 64'(WIDTH + 1));
    @(posedge clk); #1;
    check("b2b idle stall", 64'(bus.stall), 64'(0));
    check("b2b idle busy", 64'(bus.busy), 64'(0));
    check_result("b2b first");
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("b2b second accepted", 64'(bus.busy), 64'(1));
    wait_done("b2b second", n);
    @(posedge clk); #1;
    check_result("b2b second");

    // reset in the middle of an operation
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b00; bus.opnd_a = 32'd9; bus.opnd_b = 32'd9;
    @(posedge clk); #1; bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #1; rst = 1'b1; #1;
    check("midrst busy", 64'(bus.busy), 64'(0));
    check("midrst done", 64'(bus.done), 64'(0));
    check("midrst hi", 64'(bus.hi_out), 64'(0));
    check("midrst lo", 64'(bus.lo_out), 64'(0));
    @(negedge clk); rst = 1'b0;
    run_op("after rst", 2'b00, 32'd6, 32'd7, 32'd0, 32'd42);

`ifdef MULDIV_SIGNED_EN
    run_op("mult -3*5", 2'b10, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    run_op("div -7/2", 2'b11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div -9/0", 2'b11, 32'hFFFF_FFF7, 32'd0, 32'hFFFF_FFF7, 32'hFFFF_FFFF);
`else
    run_op("mult -3*5", 2'b10, 32'hFFFF_FFFD, 32'd5, 32'd4, 32'hFFFF_FFF1);
    run_op("div -7/2", 2'b11, 32'hFFFF_FFF9, 32'd2, 32'd1, 32'h7FFF_FFFC);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
